rom_loader_sdram: RTL and testbench
===================================

// Module: rom_loader_sdram
// PURPOSE
//  Upstream feeder for the SDRAM controller's toggle-handshake write port (port1).
//  Takes the HPS/ioctl ROM download byte stream, pairs bytes into 16-bit words and
//  buffers them in a small word FIFO. Issues one SDRAM write per word via req/ack toggle.
//  Flags overflow; reports busy/done so the core stays in reset until ROM is in SDRAM.
// PARAMETERS
//  FIFO_DEPTH  4   word FIFO entries (power of 2, >=2); entry = {a[23:1], ds[1:0], d[15:0]}
// PORTS
//  clk          in   1   system clock, same clock as the SDRAM controller
//  reset        in   1   synchronous, active-high
//  ioctl_downl  in   1   download window active
//  ioctl_wr     in   1   one-cycle strobe: ioctl_addr/ioctl_dout valid
//  ioctl_addr   in   25  byte address; bit 24 ignored
//  ioctl_dout   in   8   download byte
//  port1_req    out  1   toggles once per issued write
//  port1_ack    in   1   equals port1_req when the write has been accepted
//  port1_we     out  1   constant 1
//  port1_a      out  23  word address [23:1]
//  port1_ds     out  2   byte strobes {hi,lo}
//  port1_d      out  16  write data
//  busy         out  1   downl | pending byte | FIFO not empty | write outstanding
//  done         out  1   level; set when a download window has fully drained
//  overflow     out  1   sticky; word dropped because FIFO was full
// BEHAVIOUR
//  Reset: port1_req=0, port1_a=0, port1_ds=0, port1_d=0, busy=0, done=0, overflow=0,
//   FIFO empty, no pending byte; port1_we=1 always. Reset mid-transfer discards all
//   state; reset must be applied together with the controller's init.
//  Byte packing (little-endian): even byte -> d[7:0], odd byte -> d[15:8].
//  Assembly FSM:
//   EMPTY: wr even -> latch byte/word addr, go HALF. wr odd -> push {addr,2'b10,byte<<8}.
//   HALF : wr odd, same word addr -> push {addr,2'b11,{odd,even}}, go EMPTY.
//          wr odd, other word -> push held {2'b01}, then push odd {2'b10} next cycle (FLUSH).
//          wr even -> push held {2'b01}, latch new byte, stay HALF.
//          ioctl_downl falls -> push held {2'b01}, go EMPTY.
//   FLUSH: push deferred odd word, go EMPTY; an ioctl_wr arriving in FLUSH is handled as in EMPTY
//          on that same cycle after the push (FIFO takes at most 2 pushes/cycle: not allowed;
//          implementation stalls nothing - second word counts as overflow if FIFO full).
//  Push to full FIFO: word dropped, overflow<=1 (cleared only by reset or rising ioctl_downl).
//  Issue FSM: IDLE: FIFO not empty and port1_req==port1_ack -> drive port1_a/ds/d from head,
//   toggle port1_req same cycle, pop head, go WAIT. WAIT: port1_req==port1_ack -> IDLE.
//   Outputs port1_a/ds/d held stable until the next toggle. One write outstanding max.
//  Push and pop same cycle on full FIFO: pop first, push accepted (no overflow).
//  FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  done: cleared on rising ioctl_downl; set the cycle after downl low, no pending byte,
//   FIFO empty and port1_req==port1_ack. busy is combinational from registered state.
//  Latency: complete word at ioctl_wr cycle N -> port1_req toggles at N+2 if idle.
// CONFIGURATION
//  ROM_LOADER_CHECKSUM_EN defined: adds output checksum[15:0]; 16-bit wrap-around sum of
//   every ioctl_dout accepted by ioctl_wr in the window; cleared on rising ioctl_downl;
//   final value stable while done=1. Undefined: port and adder absent, all else identical.
// TESTING
//  1 bytes 0x34@0,0x12@1, ack echoes after 3 cycles -> one write a=0, ds=11, d=0x1234,
//    req 0->1, done=1 after drain.
//  2 single byte 0xAB@5 then downl falls -> write a=2, ds=10, d=0xAB00.
//  3 0x11@8 then 0x22@11 -> writes a=4 ds=01 d=0x0011, then a=5 ds=10 d=0x2200, in order.
//  4 ack held off, 2*FIFO_DEPTH+4 words streamed -> overflow=1, exactly FIFO_DEPTH+1
//    words written after ack released, addresses ascending.
//  5 reset asserted while WAIT with FIFO holding 3 words -> all outputs to reset values next
//    cycle, no further req toggles.
//  6 CHECKSUM_EN: bytes 0xFF,0xFF,0x02 -> checksum=0x0200; re-raise downl -> 0x0000.

Source files
------------

// File: rtl/rom_loader_sdram_if.sv
// SDRAM port1 write bus between the ROM loader (master) and the SDRAM controller (slave).
// Handshake: a write is outstanding while req != ack. The master toggles req to issue one write and holds a/ds/d stable until its next toggle; the slave accepts by copying req into ack.
interface rom_loader_sdram_if;
    logic        req;
    logic        ack;
    logic        we;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;

    modport master (output req, output we, output a, output ds, output d, input ack);
    modport slave  (input req, input we, input a, input ds, input d, output ack);
endinterface

// File: rtl/rom_loader_sdram.sv
// ROM download feeder: packs ioctl bytes into 16-bit words, buffers them and writes them to SDRAM port1 via req/ack toggle.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to add a 16-bit byte checksum output.
module rom_loader_sdram #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ioctl_downl,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    rom_loader_sdram_if.master  port1,
    output logic                busy,
    output logic                done,
    output logic                overflow,
`ifdef ROM_LOADER_CHECKSUM_EN
    output logic [15:0]         checksum,
`endif
    output logic [1:0]          dbg_asm_state,
    output logic                dbg_iss_state
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int EW = 41;  // {a[22:0], ds[1:0], d[15:0]}

    typedef enum logic [1:0] {A_EMPTY = 2'd0, A_HALF = 2'd1, A_FLUSH = 2'd2} asm_state_t;
    typedef enum logic {I_IDLE = 1'b0, I_WAIT = 1'b1} iss_state_t;

    asm_state_t      asm_state, asm_next;
    iss_state_t      iss_state, iss_next;

    logic [22:0]     held_waddr;
    logic [7:0]      held_byte;
    logic [EW-1:0]   def_entry;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            req_q;
    logic [22:0]     a_q;
    logic [1:0]      ds_q;
    logic [15:0]     d_q;
    logic            overflow_q, done_q, window_q, downl_q;

    logic [22:0]     wr_waddr;
    logic            wr_odd;
    logic [EW-1:0]   odd_entry, held_entry, merged_entry, push_entry;
    logic            push, push_ok, drop, pop, latch_held, latch_def;
    logic            fifo_empty, fifo_full, hs_idle, downl_rise, drained;
    logic            unused_addr_msb;

    assign wr_waddr        = ioctl_addr[23:1];
    assign wr_odd          = ioctl_addr[0];
    assign unused_addr_msb = ioctl_addr[24];
    assign odd_entry       = {wr_waddr, 2'b10, ioctl_dout, 8'h00};
    assign held_entry      = {held_waddr, 2'b01, 8'h00, held_byte};
    assign merged_entry    = {held_waddr, 2'b11, ioctl_dout, held_byte};

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign hs_idle    = (req_q == port1.ack);
    assign downl_rise = ioctl_downl & ~downl_q;

    // Byte assembly: at most one FIFO push per cycle; an odd byte that cannot be pushed now is deferred to FLUSH.
    always_comb begin
        asm_next   = asm_state;
        push       = 1'b0;
        push_entry = '0;
        latch_held = 1'b0;
        latch_def  = 1'b0;
        case (asm_state)
            A_EMPTY, A_FLUSH: begin
                if (asm_state == A_FLUSH) begin
                    push       = 1'b1;
                    push_entry = def_entry;
                    asm_next   = A_EMPTY;
                end
                if (ioctl_wr) begin
                    if (!wr_odd) begin
                        latch_held = 1'b1;
                        asm_next   = A_HALF;
                    end else if (asm_state == A_FLUSH) begin
                        latch_def = 1'b1;
                        asm_next  = A_FLUSH;
                    end else begin
                        push       = 1'b1;
                        push_entry = odd_entry;
                    end
                end
            end
            A_HALF: begin
                if (ioctl_wr) begin
                    push = 1'b1;
                    if (wr_odd && wr_waddr == held_waddr) begin
                        push_entry = merged_entry;
                        asm_next   = A_EMPTY;
                    end else if (wr_odd) begin
                        push_entry = held_entry;
                        latch_def  = 1'b1;
                        asm_next   = A_FLUSH;
                    end else begin
                        push_entry = held_entry;
                        latch_held = 1'b1;
                    end
                end else if (!ioctl_downl) begin
                    push       = 1'b1;
                    push_entry = held_entry;
                    asm_next   = A_EMPTY;
                end
            end
            default: asm_next = A_EMPTY;
        endcase
    end

    always_comb begin
        iss_next = iss_state;
        pop      = 1'b0;
        case (iss_state)
            I_IDLE: if (!fifo_empty && hs_idle) begin
                pop      = 1'b1;
                iss_next = I_WAIT;
            end
            I_WAIT: if (hs_idle) iss_next = I_IDLE;
            default: iss_next = I_IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok = push & (~fifo_full | pop);
    assign drop    = push & ~push_ok;
    assign drained = ~ioctl_downl & (asm_state == A_EMPTY) & fifo_empty & hs_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_state  <= A_EMPTY;
            iss_state  <= I_IDLE;
            held_waddr <= '0;
            held_byte  <= '0;
            def_entry  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            req_q      <= 1'b0;
            a_q        <= '0;
            ds_q       <= '0;
            d_q        <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            window_q   <= 1'b0;
            downl_q    <= 1'b0;
        end else begin
            asm_state <= asm_next;
            iss_state <= iss_next;
            downl_q   <= ioctl_downl;
            if (latch_held) begin
                held_waddr <= wr_waddr;
                held_byte  <= ioctl_dout;
            end
            if (latch_def) def_entry <= odd_entry;
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                {a_q, ds_q, d_q} <= mem[rd_ptr];
                req_q            <= ~req_q;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);
            if (downl_rise) overflow_q <= 1'b0;
            if (drop)       overflow_q <= 1'b1;
            if (downl_rise) begin
                done_q   <= 1'b0;
                window_q <= 1'b1;
            end else if (window_q && drained) begin
                done_q   <= 1'b1;
                window_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= push_entry;
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;
    always_ff @(posedge clk) begin
        if (reset)
            checksum_q <= '0;
        else if (downl_rise)
            checksum_q <= ioctl_wr ? {8'h00, ioctl_dout} : 16'h0000;
        else if (ioctl_wr)
            checksum_q <= checksum_q + {8'h00, ioctl_dout};
    end
    assign checksum = checksum_q;
`endif

    assign port1.req  = req_q;
    assign port1.we   = 1'b1;
    assign port1.a    = a_q;
    assign port1.ds   = ds_q;
    assign port1.d    = d_q;
    assign busy       = ioctl_downl | (asm_state != A_EMPTY) | ~fifo_empty | ~hs_idle;
    assign done       = done_q;
    assign overflow   = overflow_q;

    assign dbg_asm_state = asm_state;
    assign dbg_iss_state = iss_state;
endmodule

// File: tb/tb_rom_loader_sdram.sv
// Bench for rom_loader_sdram: byte-stream vectors, overflow/reset corner sequences and random windows against a write-list model.
module tb_rom_loader_sdram;
  localparam int FIFO_DEPTH = 4;
  localparam int EW = 41;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ioctl_downl = 1'b0;
  logic ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0;
  logic busy, done, overflow;
  logic [1:0] dbg_asm_state;
  logic dbg_iss_state;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  rom_loader_sdram_if port1_bus ();

  rom_loader_sdram #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .ioctl_downl(ioctl_downl),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .port1(port1_bus),
    .busy(busy),
    .done(done),
    .overflow(overflow),
`ifdef ROM_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .dbg_asm_state(dbg_asm_state),
    .dbg_iss_state(dbg_iss_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_writes = 0;
  logic [EW-1:0] exp_q[$];
  logic ack_hold = 1'b0;
  int ack_lat_min = 3;
  int ack_lat_max = 3;

  typedef struct {
    string name;
    int n;
    logic [24:0] a0, a1;
    logic [7:0] d0, d1;
    int ne;
    logic [EW-1:0] e0, e1;
  } vec_t;

  function automatic logic [EW-1:0] mk(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    return {a, ds, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every req toggle is one write, checked against the head of exp_q
  initial begin
    logic last_req;
    logic [EW-1:0] e;
    last_req = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) last_req = port1_bus.req;
      else if (port1_bus.req !== last_req) begin
        last_req = port1_bus.req;
        n_writes++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got a=0x%0h ds=%b d=0x%0h, expected no write",
                   port1_bus.a, port1_bus.ds, port1_bus.d);
        end else begin
          e = exp_q.pop_front();
          if ({port1_bus.we, port1_bus.a, port1_bus.ds, port1_bus.d} !== {1'b1, e}) begin
            n_bad++;
            $display("FAIL write: got we=%b a=0x%0h ds=%b d=0x%0h, expected we=1 a=0x%0h ds=%b d=0x%0h",
                     port1_bus.we, port1_bus.a, port1_bus.ds, port1_bus.d, e[40:18], e[17:16], e[15:0]);
          end
        end
      end
    end
  end

  // SDRAM controller model: echoes req into ack after a programmable latency
  initial begin
    int wait_cnt;
    wait_cnt = -1;
    port1_bus.ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        port1_bus.ack = 1'b0;
        wait_cnt = -1;
      end else if (ack_hold || port1_bus.req === port1_bus.ack) begin
        wait_cnt = -1;
      end else begin
        if (wait_cnt < 0) wait_cnt = $urandom_range(ack_lat_max, ack_lat_min);
        wait_cnt--;
        if (wait_cnt <= 0) begin
          port1_bus.ack = port1_bus.req;
          wait_cnt = -1;
        end
      end
    end
  end

  // driver tasks (all start and end just after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] b);
    ioctl_addr = a;
    ioctl_dout = b;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ioctl_downl = 1'b0;
    ioctl_wr = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic open_window();
    ioctl_downl = 1'b1;
    tick();
    check("window_open_done_clear", {63'd0, done}, 64'd0);
    check("window_open_overflow_clear", {63'd0, overflow}, 64'd0);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done_timeout: got done=%b after %0d cycles, expected 1", name, done, budget);
    end
    tick();
    check({name, "_busy"}, {63'd0, busy}, 64'd0);
    check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // main sequence
  initial begin
    vec_t vecs[6];
    int w0;
    logic r0;
    logic [7:0] lo, hi;
    logic [24:0] ra[30];
    logic [7:0] rd[30];
    logic [24:0] prev;
    logic [15:0] exp_sum;
    logic pend;
    logic [22:0] pw;
    logic [7:0] pb;
    int tmp, b24;

    vecs[0] = '{"pair_merge", 2, 25'd0, 25'd1, 8'h34, 8'h12, 1, mk(23'd0, 2'b11, 16'h1234), '0};
    vecs[1] = '{"single_odd", 1, 25'd5, 25'd0, 8'hAB, 8'h00, 1, mk(23'd2, 2'b10, 16'hAB00), '0};
    vecs[2] = '{"split_words", 2, 25'd8, 25'd11, 8'h11, 8'h22, 2, mk(23'd4, 2'b01, 16'h0011), mk(23'd5, 2'b10, 16'h2200)};
    vecs[3] = '{"odd_then_even", 2, 25'd3, 25'd2, 8'h56, 8'h78, 2, mk(23'd1, 2'b10, 16'h5600), mk(23'd1, 2'b01, 16'h0078)};
    vecs[4] = '{"bit24_ignored", 2, 25'h1000006, 25'h1000007, 8'h9A, 8'hBC, 1, mk(23'd3, 2'b11, 16'hBC9A), '0};
    vecs[5] = '{"even_even", 2, 25'd20, 25'd22, 8'h01, 8'h02, 2, mk(23'd10, 2'b01, 16'h0001), mk(23'd11, 2'b01, 16'h0002)};

    do_reset();
    check("reset_req", {63'd0, port1_bus.req}, 64'd0);
    check("reset_we", {63'd0, port1_bus.we}, 64'd1);
    check("reset_a", 64'(port1_bus.a), 64'd0);
    check("reset_ds", 64'(port1_bus.ds), 64'd0);
    check("reset_d", 64'(port1_bus.d), 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_overflow", {63'd0, overflow}, 64'd0);

    // table-driven byte-stream vectors
    ack_lat_min = 3;
    ack_lat_max = 3;
    for (int i = 0; i < 6; i++) begin
      w0 = n_writes;
      open_window();
      exp_q.push_back(vecs[i].e0);
      if (vecs[i].ne > 1) exp_q.push_back(vecs[i].e1);
      send_byte(vecs[i].a0, vecs[i].d0);
      if (vecs[i].n > 1) send_byte(vecs[i].a1, vecs[i].d1);
      ioctl_downl = 1'b0;
      wait_done(vecs[i].name, 200);
      check({vecs[i].name, "_write_count"}, 64'(n_writes - w0), 64'(vecs[i].ne));
      if (i == 0) check("first_write_req_high", {63'd0, port1_bus.req}, 64'd1);
    end

    // latency: complete word in cycle N -> req toggles in cycle N+2
    open_window();
    exp_q.push_back(mk(23'h20, 2'b11, 16'h5678));
    send_byte(25'h40, 8'h78);
    r0 = port1_bus.req;
    ioctl_addr = 25'h41;
    ioctl_dout = 8'h56;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    check("latency_n1_no_toggle", {63'd0, port1_bus.req}, {63'd0, r0});
    tick();
    check("latency_n2_toggle", {63'd0, port1_bus.req}, {63'd0, ~r0});
    ioctl_downl = 1'b0;
    wait_done("latency", 200);

    // overflow: ack held off while 2*FIFO_DEPTH+4 words stream in
    ack_hold = 1'b1;
    w0 = n_writes;
    open_window();
    for (int k = 0; k <= FIFO_DEPTH; k++) begin
      lo = 8'((2 * k) * 7 + 3);
      hi = 8'((2 * k + 1) * 7 + 3);
      exp_q.push_back(mk(23'(32'h80 + k), 2'b11, {hi, lo}));
    end
    for (int i = 0; i < 2 * (2 * FIFO_DEPTH + 4); i++) send_byte(25'(32'h100 + i), 8'(i * 7 + 3));
    ioctl_downl = 1'b0;
    repeat (3) tick();
    check("ovf_flag_set", {63'd0, overflow}, 64'd1);
    check("ovf_one_outstanding", 64'(n_writes - w0), 64'd1);
    check("ovf_busy_while_held", {63'd0, busy}, 64'd1);
    ack_hold = 1'b0;
    wait_done("ovf", 500);
    check("ovf_total_writes", 64'(n_writes - w0), 64'(FIFO_DEPTH + 1));
    check("ovf_flag_sticky", {63'd0, overflow}, 64'd1);

    // reset while a write is outstanding and 3 words are queued
    ack_hold = 1'b1;
    w0 = n_writes;
    open_window();
    exp_q.push_back(mk(23'h90, 2'b11, 16'hB1A0));
    for (int k = 0; k < 4; k++) begin
      send_byte(25'(32'h120 + 2 * k), 8'hA0 + 8'(k));
      send_byte(25'(32'h121 + 2 * k), 8'hB1 + 8'(k));
    end
    repeat (2) tick();
    check("rst_mid_one_issued", 64'(n_writes - w0), 64'd1);
    reset = 1'b1;
    ioctl_downl = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_req", {63'd0, port1_bus.req}, 64'd0);
    check("rst_mid_a", 64'(port1_bus.a), 64'd0);
    check("rst_mid_ds", 64'(port1_bus.ds), 64'd0);
    check("rst_mid_d", 64'(port1_bus.d), 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_overflow", {63'd0, overflow}, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    ack_hold = 1'b0;
    exp_q.delete();
    w0 = n_writes;
    repeat (30) tick();
    check("rst_mid_no_more_writes", 64'(n_writes - w0), 64'd0);
    check("rst_mid_idle_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_idle_done", {63'd0, done}, 64'd0);

`ifdef ROM_LOADER_CHECKSUM_EN
    open_window();
    exp_q.push_back(mk(23'h100, 2'b11, 16'hFFFF));
    exp_q.push_back(mk(23'h101, 2'b01, 16'h0002));
    send_byte(25'h200, 8'hFF);
    send_byte(25'h201, 8'hFF);
    send_byte(25'h202, 8'h02);
    ioctl_downl = 1'b0;
    wait_done("cksum", 200);
    check("cksum_value", 64'(checksum), 64'h0200);
    ioctl_downl = 1'b1;
    tick();
    check("cksum_cleared", 64'(checksum), 64'h0000);
    ioctl_downl = 1'b0;
    wait_done("cksum_empty", 50);
`endif

    // random windows against the write-list model
    ack_lat_min = 1;
    ack_lat_max = 3;
    for (int w = 0; w < 4; w++) begin
      prev = 25'(32'h300 * w);
      exp_sum = '0;
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(3, 0) == 0 || i == 0) begin
          tmp = $urandom_range(255, 0);
          b24 = $urandom_range(1, 0);
          ra[i] = {b24[0], 24'(tmp)};
        end else begin
          ra[i] = prev + 25'd1;
        end
        prev = ra[i];
        tmp = $urandom_range(255, 0);
        rd[i] = 8'(tmp);
        exp_sum = exp_sum + {8'h00, rd[i]};
      end
      pend = 1'b0;
      pw = '0;
      pb = '0;
      for (int i = 0; i < 30; i++) begin
        if (!ra[i][0]) begin
          if (pend) exp_q.push_back(mk(pw, 2'b01, {8'h00, pb}));
          pend = 1'b1;
          pw = ra[i][23:1];
          pb = rd[i];
        end else if (pend && pw == ra[i][23:1]) begin
          exp_q.push_back(mk(pw, 2'b11, {rd[i], pb}));
          pend = 1'b0;
        end else begin
          if (pend) exp_q.push_back(mk(pw, 2'b01, {8'h00, pb}));
          pend = 1'b0;
          exp_q.push_back(mk(ra[i][23:1], 2'b10, {rd[i], 8'h00}));
        end
      end
      if (pend) exp_q.push_back(mk(pw, 2'b01, {8'h00, pb}));
      w0 = n_writes + exp_q.size();
      open_window();
      for (int i = 0; i < 30; i++) begin
        send_byte(ra[i], rd[i]);
        repeat ($urandom_range(10, 6)) tick();
      end
      ioctl_downl = 1'b0;
      wait_done("rand", 2000);
      check("rand_write_count", 64'(n_writes), 64'(w0));
      check("rand_no_overflow", {63'd0, overflow}, 64'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
      check("rand_checksum", 64'(checksum), 64'(exp_sum));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
